memory_arbiter: RTL and testbench

Shares one single-ported unified memory between the instruction-fetch port and the data-memory port of the RISC-V core. Arbitrates between the two requesters and keeps one transaction outstanding at a time. Latches the winning request, drives the memory request handshake, and routes the registered response back to the winner. Sits between program_counter/data path and a single memory macro; busy_o is used by the core to stall the PC.

---
 rtl/memory_arbiter.sv | 112 +++++++++++
 tb/tb_memory_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Two-port arbiter sharing one single-ported memory between instruction fetch
// and data access; one outstanding transaction, alternating priority on ties.
module memory_arbiter #(
  parameter int RegBits         = 32,
  parameter bit PrioDataOnReset = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               if_req_i,
  input  logic [RegBits-1:0] if_addr_i,
  output logic               if_gnt_o,
  output logic               if_rvalid_o,
  output logic [RegBits-1:0] if_rdata_o,
  input  logic               dm_req_i,
  input  logic [RegBits-1:0] dm_addr_i,
  input  logic [1:0]         dm_we_i,
  input  logic [RegBits-1:0] dm_wdata_i,
  output logic               dm_gnt_o,
  output logic               dm_rvalid_o,
  output logic [RegBits-1:0] dm_rdata_o,
  output logic               mem_req_o,
  output logic [RegBits-1:0] mem_addr_o,
  output logic [1:0]         mem_we_o,
  output logic [RegBits-1:0] mem_wdata_o,
  input  logic               mem_ready_i,
  input  logic               mem_rvalid_i,
  input  logic [RegBits-1:0] mem_rdata_i,
  output logic               busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state, state_next;
  logic               prio_d_q;
  logic               owner_d_q;
  logic               pick_d;
  logic               start;
  logic [RegBits-1:0] addr_q;
  logic [RegBits-1:0] wdata_q;
  logic [1:0]         we_q;
  logic [RegBits-1:0] if_rdata_q;
  logic [RegBits-1:0] dm_rdata_q;
  logic [RegBits-1:0] resp_data;

  // Data port wins when it is the only requester or when it holds the tie-break.
  assign pick_d    = dm_req_i & (~if_req_i | prio_d_q);
  assign start     = (state == IDLE) & (if_req_i | dm_req_i);
  assign resp_data = (we_q == 2'b00) ? mem_rdata_i : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if_gnt_o   = 1'b0;
    dm_gnt_o   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if_gnt_o   = ~pick_d;
          dm_gnt_o   = pick_d;
          state_next = ISSUE;
        end
      end
      ISSUE: if (mem_ready_i) state_next = WAIT;
      WAIT:  if (mem_rvalid_i) state_next = RESP;
      RESP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_d_q   <= PrioDataOnReset;
      owner_d_q  <= 1'b0;
      addr_q     <= '0;
      we_q       <= 2'b00;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (start) begin
        // Fetches never write, so their size and data are forced to zero.
        addr_q    <= pick_d ? dm_addr_i : if_addr_i;
        we_q      <= pick_d ? dm_we_i : 2'b00;
        wdata_q   <= pick_d ? dm_wdata_i : '0;
        owner_d_q <= pick_d;
        prio_d_q  <= ~pick_d;
      end
      if ((state == WAIT) && mem_rvalid_i) begin
        if (owner_d_q) dm_rdata_q <= resp_data;
        else           if_rdata_q <= resp_data;
      end
    end
  end

  assign mem_req_o   = (state == ISSUE);
  assign mem_addr_o  = addr_q;
  assign mem_we_o    = we_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state != IDLE);
  assign if_rvalid_o = (state == RESP) & ~owner_d_q;
  assign dm_rvalid_o = (state == RESP) & owner_d_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: fetch, write, tie alternation, backpressure,
// spurious responses and reset while waiting on memory.
module tb_memory_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i = 1'b0;
  logic [31:0] dm_addr_i = '0;
  logic [1:0]  dm_we_i = 2'b00;
  logic [31:0] dm_wdata_i = '0;
  logic        dm_gnt_o, dm_rvalid_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [1:0]  mem_we_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  memory_arbiter #(.RegBits(32), .PrioDataOnReset(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_addr_i(dm_addr_i), .dm_we_i(dm_we_i),
    .dm_wdata_i(dm_wdata_i), .dm_gnt_o(dm_gnt_o), .dm_rvalid_o(dm_rvalid_o),
    .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  initial forever #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    if_req_i = 1'b0; dm_req_i = 1'b0;
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // One complete transaction from IDLE; caller has already set requester inputs.
  task automatic do_txn(input string tag, input bit exp_d, input logic [31:0] exp_addr,
                        input logic [1:0] exp_we, input logic [31:0] exp_wdata,
                        input logic [31:0] rd, input int stall, input bit drop);
    logic [31:0] exp_rd;
    exp_rd = (exp_we == 2'b00) ? rd : 32'h0;
    #1;
    check({tag, "_if_gnt"}, {31'b0, if_gnt_o}, {31'b0, ~exp_d});
    check({tag, "_dm_gnt"}, {31'b0, dm_gnt_o}, {31'b0, exp_d});
    check({tag, "_idle_busy"}, {31'b0, busy_o}, 32'h0);
    tick();
    if (drop) begin
      if_req_i = 1'b0;
      dm_req_i = 1'b0;
    end
    for (int s = 0; s <= stall; s++) begin
      mem_ready_i  = (s == stall);
      mem_rvalid_i = (s < stall);
      mem_rdata_i  = 32'hBAD0_0BAD;
      #1;
      check({tag, "_mem_req"}, {31'b0, mem_req_o}, 32'h1);
      check({tag, "_mem_addr"}, mem_addr_o, exp_addr);
      check({tag, "_mem_we"}, {30'b0, mem_we_o}, {30'b0, exp_we});
      check({tag, "_mem_wdata"}, mem_wdata_o, exp_wdata);
      check({tag, "_issue_busy"}, {31'b0, busy_o}, 32'h1);
      check({tag, "_issue_gnt"}, {30'b0, if_gnt_o, dm_gnt_o}, 32'h0);
      check({tag, "_issue_rvalid"}, {30'b0, if_rvalid_o, dm_rvalid_o}, 32'h0);
      tick();
    end
    mem_ready_i  = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rd;
    #1;
    check({tag, "_wait_req"}, {31'b0, mem_req_o}, 32'h0);
    check({tag, "_wait_busy"}, {31'b0, busy_o}, 32'h1);
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    check({tag, "_if_rvalid"}, {31'b0, if_rvalid_o}, {31'b0, ~exp_d});
    check({tag, "_dm_rvalid"}, {31'b0, dm_rvalid_o}, {31'b0, exp_d});
    check({tag, "_rdata"}, exp_d ? dm_rdata_o : if_rdata_o, exp_rd);
    check({tag, "_resp_busy"}, {31'b0, busy_o}, 32'h1);
    tick();
    $display("txn %s: owner=%s addr=0x%08h we=%0d rdata=0x%08h", tag,
             exp_d ? "D" : "I", exp_addr, exp_we, exp_rd);
  endtask

  initial begin
    do_reset();
    #1;
    check("rst_busy", {31'b0, busy_o}, 32'h0);
    check("rst_mem_req", {31'b0, mem_req_o}, 32'h0);
    check("rst_mem_addr", mem_addr_o, 32'h0);
    check("rst_rvalid", {30'b0, if_rvalid_o, dm_rvalid_o}, 32'h0);

    // Single fetch, prio stays with data afterwards.
    if_req_i = 1'b1; if_addr_i = 32'h10;
    do_txn("fetch", 1'b0, 32'h10, 2'b00, 32'h0, 32'h0050_0093, 0, 1'b1);
    check("fetch_done_rvalid", {31'b0, if_rvalid_o}, 32'h0);
    check("fetch_hold_rdata", if_rdata_o, 32'h0050_0093);

    // Spurious response while idle.
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("spur_idle_busy", {31'b0, busy_o}, 32'h0);
      check("spur_idle_rvalid", {30'b0, if_rvalid_o, dm_rvalid_o}, 32'h0);
    end
    mem_rvalid_i = 1'b0;

    // Data word write returns zero read data.
    dm_req_i = 1'b1; dm_addr_i = 32'h80; dm_we_i = 2'b11; dm_wdata_i = 32'hDEAD_BEEF;
    do_txn("write", 1'b1, 32'h80, 2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1'b1);

    // Tie after reset: D, I, D, I with both requesters held.
    do_reset();
    if_req_i = 1'b1; if_addr_i = 32'h100;
    dm_req_i = 1'b1; dm_addr_i = 32'h200; dm_we_i = 2'b00; dm_wdata_i = 32'h55;
    do_txn("tie0", 1'b1, 32'h200, 2'b00, 32'h55, 32'hA000_0000, 0, 1'b0);
    do_txn("tie1", 1'b0, 32'h100, 2'b00, 32'h0,  32'hA000_0001, 0, 1'b0);
    do_txn("tie2", 1'b1, 32'h200, 2'b00, 32'h55, 32'hA000_0002, 0, 1'b0);
    do_txn("tie3", 1'b0, 32'h100, 2'b00, 32'h0,  32'hA000_0003, 0, 1'b0);

    // Backpressure with both requesting; data holds priority after I won last.
    dm_we_i = 2'b10; dm_wdata_i = 32'h0000_BEEF; dm_addr_i = 32'h204;
    do_txn("bp", 1'b1, 32'h204, 2'b10, 32'h0000_BEEF, 32'hCAFE_F00D, 4, 1'b1);

    // Data read that leaves prio with fetch, then reset while in WAIT.
    dm_req_i = 1'b1; dm_addr_i = 32'h300; dm_we_i = 2'b00;
    #1;
    check("rw_dm_gnt", {31'b0, dm_gnt_o}, 32'h1);
    tick();
    dm_req_i = 1'b0; mem_ready_i = 1'b1;
    #1;
    check("rw_mem_req", {31'b0, mem_req_o}, 32'h1);
    tick();
    mem_ready_i = 1'b0;
    #1;
    check("rw_wait_busy", {31'b0, busy_o}, 32'h1);
    rst_i = 1'b1;
    #1;
    check("rw_rst_busy", {31'b0, busy_o}, 32'h0);
    check("rw_rst_addr", mem_addr_o, 32'h0);
    check("rw_rst_we", {30'b0, mem_we_o}, 32'h0);
    check("rw_rst_dm_rdata", dm_rdata_o, 32'h0);
    rst_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_0BAD;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rw_late_rvalid", {30'b0, if_rvalid_o, dm_rvalid_o}, 32'h0);
      check("rw_late_busy", {31'b0, busy_o}, 32'h0);
    end
    mem_rvalid_i = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h400;
    dm_req_i = 1'b1; dm_addr_i = 32'h500; dm_we_i = 2'b00; dm_wdata_i = 32'h0;
    do_txn("rw_prio", 1'b1, 32'h500, 2'b00, 32'h0, 32'h0BAD_F00D, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
